// File: rtl/i2c_byte_tx.sv
// I2C master byte transmitter: shifts one byte MSB-first onto an open-drain bus,
// clocks a ninth ACK bit, samples the slave ACK and honours clock stretching.
//
// state      | meaning
// -----------|---------------------------------------------------------------
// S_IDLE     | waiting for a request while SCL is low
// S_SETUP    | put the next data bit (or release for ACK) on SDA, SCL low
// S_WAIT     | quarter-period delay, then jump to the return state
// S_CLK_UP   | release SCL and wait until the bus really is high (stretch)
// S_CLK_DOWN | sample ACK in the ninth slot, pull SCL low, advance the bit
// S_DONE     | one-cycle completion pulse, bus left with SCL low, SDA free
module i2c_byte_tx #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_ack,
  input  logic       i_sda,
  input  logic       i_scl,
  output logic       o_sda_drive,
  output logic       o_scl_drive
);

  localparam int Q  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int TW = $clog2(Q + 1);
  localparam logic [TW-1:0] Q_LD = TW'(Q);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_WAIT     = 3'd2,
    S_CLK_UP   = 3'd3,
    S_CLK_DOWN = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t          r_state, w_state;
  state_t          r_ret, w_ret;
  logic [7:0]      r_shift, w_shift;
  logic [3:0]      r_bit, w_bit;
  logic [TW-1:0]   r_tmo, w_tmo;
  logic            r_sda, w_sda;
  logic            r_scl, w_scl;
  logic            r_ack, w_ack;
  logic            w_ready;
  logic            w_done;

  assign w_ready     = (r_state == S_IDLE) & ~i_scl;
  assign o_ready     = w_ready;
  assign o_done      = w_done;
  assign o_ack       = r_ack;
  assign o_sda_drive = r_sda;
  assign o_scl_drive = r_scl;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ret   <= S_IDLE;
      r_shift <= 8'h00;
      r_bit   <= 4'd0;
      r_tmo   <= '0;
      r_sda   <= 1'b1;
      r_scl   <= 1'b1;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ret   <= w_ret;
      r_shift <= w_shift;
      r_bit   <= w_bit;
      r_tmo   <= w_tmo;
      r_sda   <= w_sda;
      r_scl   <= w_scl;
      r_ack   <= w_ack;
    end
  end

  always_comb begin
    w_state = r_state;
    w_ret   = r_ret;
    w_shift = r_shift;
    w_bit   = r_bit;
    w_tmo   = r_tmo;
    w_sda   = r_sda;
    w_scl   = r_scl;
    w_ack   = r_ack;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req && w_ready) begin
          w_shift = i_data;
          w_bit   = 4'd0;
          w_ack   = 1'b0;
          w_scl   = 1'b0;
          w_state = S_SETUP;
        end
      end
      S_SETUP: begin
        w_sda   = (r_bit == 4'd8) ? 1'b1 : r_shift[7];
        w_scl   = 1'b0;
        w_tmo   = Q_LD;
        w_ret   = S_CLK_UP;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        if (r_tmo == '0) begin
          w_state = r_ret;
          // SCL must already be released while in CLK_UP, otherwise our own
          // low drive would look like a stretch and add a cycle per bit.
          if (r_ret == S_CLK_UP) w_scl = 1'b1;
        end else begin
          w_tmo = r_tmo - 1'b1;
        end
      end
      S_CLK_UP: begin
        w_scl = 1'b1;
        if (i_scl) begin
          w_tmo   = Q_LD;
          w_ret   = S_CLK_DOWN;
          w_state = S_WAIT;
        end
      end
      S_CLK_DOWN: begin
        if (r_bit == 4'd8) w_ack = ~i_sda;
        w_scl   = 1'b0;
        w_shift = {r_shift[6:0], 1'b0};
        w_bit   = r_bit + 4'd1;
        w_tmo   = Q_LD;
        w_ret   = (r_bit < 4'd8) ? S_SETUP : S_DONE;
        w_state = S_WAIT;
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_sda   = 1'b1;
        w_scl   = 1'b0;
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_byte_tx.sv
// Self-checking bench for i2c_byte_tx: directed bus scenarios plus random bytes
// checked against a bit-level model of the serial pattern, ACK and timing.
module tb_i2c_byte_tx;

  localparam int CLK_FREQ = 800_000;
  localparam int I2C_FREQ = 100_000;
  localparam int Q        = CLK_FREQ / (4 * I2C_FREQ);
  localparam int BYTE_CYC = 9 * (3 * Q + 6) + 1;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_req;
  logic [7:0] i_data;
  logic       o_ready, o_done, o_ack;
  logic       i_sda, i_scl;
  logic       o_sda_drive, o_scl_drive;

  logic pull_low, stretch, slave_ack;
  int   rise_total = 0, fall_total = 0, rise_base, fall_base, mon_err = 0;
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;
  logic q_sda[$];
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  // Open-drain bus: another master may hold SCL low, the slave may stretch it
  // and pulls SDA low between the 8th and 9th SCL falls when it acknowledges.
  assign i_scl = o_scl_drive & ~pull_low & ~stretch;
  assign i_sda = o_sda_drive & ~(slave_ack & ((fall_total - fall_base) == 8));

  i2c_byte_tx #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_data(i_data),
    .o_ready(o_ready), .o_done(o_done), .o_ack(o_ack),
    .i_sda(i_sda), .i_scl(i_scl),
    .o_sda_drive(o_sda_drive), .o_scl_drive(o_scl_drive)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_scl_drive && !prev_scl) begin
        rise_total <= rise_total + 1;
        q_sda.push_back(o_sda_drive);
      end
      if (!o_scl_drive && prev_scl) fall_total <= fall_total + 1;
      if ((prev_scl || o_scl_drive) && (o_sda_drive != prev_sda)) mon_err <= mon_err + 1;
    end
    prev_scl <= o_scl_drive;
    prev_sda <= o_sda_drive;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bits(input string tag, input logic [7:0] data);
    logic [8:0] got, exp;
    exp = {data, 1'b1};
    got = '1;
    chk({tag, "_rises"}, rise_total - rise_base, 9);
    for (int i = 0; i < 9; i++)
      if (rise_base + i < q_sda.size()) got[8-i] = q_sda[rise_base + i];
    chk({tag, "_bits"}, 32'(got), 32'(exp));
  endtask

  task automatic run_byte(input logic [7:0] data, input logic ack_en, input int st_bit,
                          input int st_len, input int midreq_at,
                          output int lat, output int pulses, output int st_err,
                          output int done_at);
    int   acc, st_cnt;
    bit   st_on, st_cnting;
    logic sda_hold;
    lat = -1; pulses = 0; st_err = 0; done_at = -1;
    st_on = 0; st_cnting = 0; st_cnt = 0; sda_hold = 1'b1;
    chk("ready_before_req", o_ready, 1);
    i_data = data;
    i_req  = 1'b1;
    acc    = cyc;
    @(posedge i_clk); #1;
    i_req    = 1'b0;
    pull_low = 1'b0;
    chk("scl_low_after_accept", o_scl_drive, 0);
    @(negedge i_clk); #1;
    rise_base = rise_total;
    fall_base = fall_total;
    slave_ack = ack_en;
    for (int n = 0; n < 4000; n++) begin
      @(posedge i_clk); #1;
      i_req = (midreq_at > 0) && ((cyc - acc) == midreq_at);
      if (st_len > 0) begin
        if (st_cnting) begin
          if (o_sda_drive !== sda_hold) st_err++;
          st_cnt++;
          if (st_cnt == st_len) begin
            stretch   = 1'b0;
            st_cnting = 0;
          end
        end else if (!st_on && (rise_total - rise_base) == st_bit && !o_scl_drive) begin
          stretch = 1'b1;
          st_on   = 1;
        end else if (st_on && stretch && o_scl_drive) begin
          st_cnting = 1;
          st_cnt    = 0;
          sda_hold  = o_sda_drive;
        end
      end
      if (o_done) begin
        pulses++;
        if (lat < 0) begin
          lat     = cyc - acc;
          done_at = cyc;
        end
      end else if (pulses > 0) begin
        break;
      end
    end
    i_req     = 1'b0;
    stretch   = 1'b0;
    slave_ack = 1'b0;
  endtask

  initial begin
    int lat, pul, se, d1, d2, dn;
    logic [7:0] rd;
    logic       ra;
    int         rl, rb;

    i_rst = 1'b1; i_req = 1'b0; i_data = 8'h00;
    pull_low = 1'b0; stretch = 1'b0; slave_ack = 1'b0;
    rise_base = 0; fall_base = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_sda", o_sda_drive, 1);
    chk("rst_scl", o_scl_drive, 1);
    chk("rst_ack", o_ack, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ready_scl_high", o_ready, 0);
    #2 i_rst = 1'b0;
    @(posedge i_clk); #1;

    // request while SCL is high must be ignored
    i_req = 1'b1; i_data = 8'h00;
    @(posedge i_clk); #1;
    chk("gate_scl", o_scl_drive, 1);
    chk("gate_sda", o_sda_drive, 1);
    chk("gate_ready", o_ready, 0);
    i_req = 1'b0;
    pull_low = 1'b1;
    #1;
    chk("gate_ready_low", o_ready, 1);

    run_byte(8'hA5, 1'b1, 0, 0, 50, lat, pul, se, dn);
    chk("a5_latency", lat, BYTE_CYC);
    chk("a5_pulses", pul, 1);
    chk("a5_ack", o_ack, 1);
    check_bits("a5", 8'hA5);

    run_byte(8'hFF, 1'b0, 0, 0, 0, lat, pul, se, dn);
    chk("ff_latency", lat, BYTE_CYC);
    chk("ff_ack", o_ack, 0);
    check_bits("ff", 8'hFF);

    run_byte(8'h96, 1'b1, 3, 20, 0, lat, pul, se, dn);
    chk("stretch_latency", lat, BYTE_CYC + 20);
    chk("stretch_sda_stable", se, 0);
    chk("stretch_pulses", pul, 1);
    check_bits("stretch", 8'h96);

    run_byte(8'h3C, 1'b1, 0, 0, 0, lat, pul, se, d1);
    check_bits("b2b_first", 8'h3C);
    chk("b2b_scl_low", o_scl_drive, 0);
    run_byte(8'hC3, 1'b0, 0, 0, 0, lat, pul, se, d2);
    check_bits("b2b_second", 8'hC3);
    chk("b2b_gap", d2 - d1, BYTE_CYC + 1);
    chk("b2b_ack", o_ack, 0);

    // reset during the high phase of bit 5 while SDA is driven low
    i_data = 8'h5A; i_req = 1'b1;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    @(negedge i_clk); #1;
    rise_base = rise_total;
    fall_base = fall_total;
    for (int n = 0; n < 500; n++) begin
      @(posedge i_clk); #1;
      if ((rise_total - rise_base) == 6 && o_scl_drive) break;
    end
    chk("rstmid_reach_bit5", rise_total - rise_base, 6);
    chk("rstmid_sda_low_before", o_sda_drive, 0);
    #2 i_rst = 1'b1;
    #1;
    chk("rstmid_sda", o_sda_drive, 1);
    chk("rstmid_scl", o_scl_drive, 1);
    chk("rstmid_ack", o_ack, 0);
    @(posedge i_clk); @(posedge i_clk);
    #3 i_rst = 1'b0;
    pul = 0;
    for (int n = 0; n < 150; n++) begin
      @(posedge i_clk); #1;
      if (o_done) pul++;
    end
    chk("rstmid_no_done", pul, 0);
    chk("rstmid_ready_scl_high", o_ready, 0);
    pull_low = 1'b1;
    #1;
    chk("rstmid_idle", o_ready, 1);

    for (int k = 0; k < 4; k++) begin
      rd = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      rl = $urandom_range(0, 12);
      rb = $urandom_range(0, 8);
      run_byte(rd, ra, rb, rl, 0, lat, pul, se, dn);
      chk("rnd_latency", lat, BYTE_CYC + rl);
      chk("rnd_pulses", pul, 1);
      chk("rnd_ack", o_ack, 32'(ra));
      chk("rnd_sda_stable", se, 0);
      check_bits("rnd", rd);
    end

    chk("sda_only_changes_scl_low", mon_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
